imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Accepts a framed byte stream (LEN_HI, LEN_LO, N x {HI, LO}, CHK).
// Words are written to instruction RAM from address 0. The core is held
// in reset until the XOR checksum over the frame verifies.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              imem_we,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  // Word count limit. N == CAP is legal, so the last write address is CAP-1.
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state, state_d;
  logic [7:0]        len_hi, len_hi_d;
  logic [15:0]       len, len_d;
  logic [7:0]        hi, hi_d;
  logic [15:0]       wcnt, wcnt_d;
  logic [7:0]        csum, csum_d;

  logic              rx_ready_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;
  logic              we_d;
  logic              core_rst_n_d;
  logic              done_d;
  logic              err_d;

  logic              accept;
  logic [15:0]       n_len;
  logic [15:0]       wcnt_inc;

  // rx_ready is registered, so a transfer never depends combinationally on rx_valid.
  assign accept   = rx_valid & rx_ready;
  assign n_len    = {len_hi, rx_data};
  assign wcnt_inc = wcnt + 16'd1;

  // Next-state and next-output logic; every register holds unless a byte is accepted.
  always_comb begin
    state_d      = state;
    len_hi_d     = len_hi;
    len_d        = len;
    hi_d         = hi;
    wcnt_d       = wcnt;
    csum_d       = csum;
    addr_d       = imem_addr;
    wdata_d      = imem_wdata;
    we_d         = 1'b0;
    core_rst_n_d = core_rst_n;
    done_d       = load_done;
    err_d        = load_err;

    // The CHK byte itself is excluded from the running XOR.
    if (accept && state != S_CHK)
      csum_d = csum ^ rx_data;

    case (state)
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = n_len;
          if (n_len == 16'd0) begin
            state_d = S_CHK;
          end else if ({1'b0, n_len} > CAP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = wcnt[ADDR_W-1:0];
          wdata_d = {hi, rx_data};
          wcnt_d  = wcnt_inc;
          state_d = (wcnt_inc == len) ? S_CHK : S_DATA_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (rx_data == csum) begin
            state_d      = S_RUN;
            core_rst_n_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = state;  // S_RUN / S_ERR are terminal until rst
    endcase

    // Ready drops on the same edge that enters a terminal state.
    rx_ready_d = (state_d != S_RUN) && (state_d != S_ERR);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN_HI;
    else     state <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi     <= '0;
      len        <= '0;
      hi         <= '0;
      wcnt       <= '0;
      csum       <= '0;
      rx_ready   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      imem_we    <= 1'b0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      len_hi     <= len_hi_d;
      len        <= len_d;
      hi         <= hi_d;
      wcnt       <= wcnt_d;
      csum       <= csum_d;
      rx_ready   <= rx_ready_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      imem_we    <= we_d;
      core_rst_n <= core_rst_n_d;
      load_done  <= done_d;
      load_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, zero length, oversize/max length,
// bad checksum, rx_valid gaps and reset mid-load.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              imem_we;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  int total = 0;
  int bad   = 0;

  logic [23:0] wq[$];    // observed writes {addr, data}
  logic [23:0] exp_w[$];
  logic [7:0]  frm[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_we(imem_we), .core_rst_n(core_rst_n), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Capture every write pulse away from the active edge.
  always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  // During the gap the byte is already on rx_data with rx_valid low.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      rx_data = b; rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data = b; rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin @(negedge clk); n++; end
    if (!rx_ready) check("rdy_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gapmax);
    foreach (frm[i]) send_byte(frm[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    wq.delete();
    rst = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wq.size(), exp_w.size());
    foreach (exp_w[i])
      if (i < wq.size()) check({tag, "_wr"}, wq[i], exp_w[i]);
  endtask

  task automatic load_nominal(input logic [7:0] chk);
    frm = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, chk};
    exp_w = '{{8'h00, 16'h1234}, {8'h01, 16'hABCD}, {8'h02, 16'h0F0F}};
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_rdy",   rx_ready,   0);
    check("rst_addr",  imem_addr,  0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_we",    imem_we,    0);
    check("rst_crst",  core_rst_n, 0);
    check("rst_done",  load_done,  0);
    check("rst_err",   load_err,   0);
    do_reset();
    check("rdy_pre", rx_ready, 0);
    @(negedge clk);
    check("rdy_rise", rx_ready, 1);

    // Nominal back-to-back load
    load_nominal(8'h43);
    send_frame(0);
    check("nom_done", load_done,  1);
    check("nom_crst", core_rst_n, 1);
    check("nom_err",  load_err,   0);
    check("nom_rdy",  rx_ready,   0);
    repeat (3) @(negedge clk);
    check_writes("nom");
    check("nom_hold", load_done, 1);

    // Zero length
    do_reset();
    frm = '{8'h00, 8'h00, 8'h00};
    exp_w.delete();
    send_frame(0);
    check("zero_done", load_done, 1);
    check("zero_crst", core_rst_n, 1);
    check_writes("zero");

    // Oversize length
    do_reset();
    frm = '{8'h01, 8'h01};
    send_frame(0);
    check("ovr_err",  load_err,   1);
    check("ovr_rdy",  rx_ready,   0);
    check("ovr_crst", core_rst_n, 0);
    repeat (3) @(negedge clk);
    check_writes("ovr");

    // Maximum length: 256 words {i, ~i}; XOR of all data bytes is 0, CHK = 01
    do_reset();
    frm = '{8'h01, 8'h00};
    exp_w.delete();
    for (int i = 0; i < 256; i++) begin
      frm.push_back(8'(i));
      frm.push_back(~8'(i));
      exp_w.push_back({8'(i), 8'(i), ~8'(i)});
    end
    frm.push_back(8'h01);
    send_frame(0);
    check("max_done", load_done, 1);
    check("max_err",  load_err,  0);
    check_writes("max");
    check("max_last", (wq.size() > 0) ? wq[wq.size()-1] : 24'h0, 24'hFFFF00);

    // Checksum error
    do_reset();
    load_nominal(8'h42);
    send_frame(0);
    check("chk_err",  load_err,   1);
    check("chk_done", load_done,  0);
    check("chk_crst", core_rst_n, 0);
    check("chk_rdy",  rx_ready,   0);
    repeat (3) @(negedge clk);
    check_writes("chk");

    // Gaps in rx_valid
    do_reset();
    load_nominal(8'h43);
    send_frame(5);
    check("gap_done", load_done, 1);
    check("gap_err",  load_err,  0);
    repeat (2) @(negedge clk);
    check_writes("gap");

    // Reset after the 5th byte, then a fresh frame
    do_reset();
    frm = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    send_frame(0);
    rst = 1'b1;
    #1;
    check("mid_rdy",   rx_ready,   0);
    check("mid_addr",  imem_addr,  0);
    check("mid_wdata", imem_wdata, 0);
    check("mid_we",    imem_we,    0);
    check("mid_crst",  core_rst_n, 0);
    check("mid_done",  load_done,  0);
    check("mid_err",   load_err,   0);
    @(negedge clk);
    wq.delete();
    rst = 1'b0;
    load_nominal(8'h43);
    send_frame(0);
    check("re_done", load_done,  1);
    check("re_crst", core_rst_n, 1);
    repeat (2) @(negedge clk);
    check_writes("re");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
